// File: rtl/tx_bram_filler.sv
// Write side of the TX packet BRAM: streams AXI-S words into the BRAM from address 0,
// starts the OFDM transmitter once the packet is committed and waits for it to finish.
module tx_bram_filler #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 64,
  parameter int START_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  phy_tx_arestn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  phy_tx_start,
  input  logic                  phy_tx_started,
  input  logic                  phy_tx_done,
  output logic [ADDR_WIDTH:0]   pkt_words,
  output logic                  busy,
  output logic                  overflow_err,
  output logic                  start_timeout_err,
  output logic [15:0]           tx_pkt_cnt
);

  localparam int TO_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] WPTR_MAX = '1;
  localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FILL, DROP, START, WAIT_STARTED, WAIT_DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wptr, wptr_nxt;
  logic [TO_W-1:0]         to_cnt, to_cnt_nxt;
  logic [ADDR_WIDTH:0]     pkt_words_nxt;
  logic [15:0]             tx_pkt_cnt_nxt;
  logic                    we_nxt, start_nxt, ovf_nxt, to_err_nxt, tready_nxt;
  logic [ADDR_WIDTH-1:0]   waddr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_nxt;
  logic                    accept;

  assign accept = s_axis_tvalid & s_axis_tready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      state             <= IDLE;
      wptr              <= '0;
      to_cnt            <= '0;
      s_axis_tready     <= 1'b0;
      bram_we           <= 1'b0;
      bram_waddr        <= '0;
      bram_wdata        <= '0;
      phy_tx_start      <= 1'b0;
      pkt_words         <= '0;
      overflow_err      <= 1'b0;
      start_timeout_err <= 1'b0;
      tx_pkt_cnt        <= '0;
    end else begin
      state             <= state_nxt;
      wptr              <= wptr_nxt;
      to_cnt            <= to_cnt_nxt;
      s_axis_tready     <= tready_nxt;
      bram_we           <= we_nxt;
      bram_waddr        <= waddr_nxt;
      bram_wdata        <= wdata_nxt;
      phy_tx_start      <= start_nxt;
      pkt_words         <= pkt_words_nxt;
      overflow_err      <= ovf_nxt;
      start_timeout_err <= to_err_nxt;
      tx_pkt_cnt        <= tx_pkt_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    wptr_nxt       = wptr;
    to_cnt_nxt     = to_cnt;
    pkt_words_nxt  = pkt_words;
    tx_pkt_cnt_nxt = tx_pkt_cnt;
    we_nxt         = 1'b0;
    waddr_nxt      = bram_waddr;
    wdata_nxt      = bram_wdata;
    start_nxt      = 1'b0;
    ovf_nxt        = 1'b0;
    to_err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        wptr_nxt = '0;
        if (accept) begin
          we_nxt    = 1'b1;
          waddr_nxt = '0;
          wdata_nxt = s_axis_tdata;
          wptr_nxt  = ADDR_WIDTH'(1);
          if (s_axis_tlast) begin
            pkt_words_nxt = (ADDR_WIDTH+1)'(1);
            state_nxt     = START;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          we_nxt    = 1'b1;
          waddr_nxt = wptr;
          wdata_nxt = s_axis_tdata;
          wptr_nxt  = wptr + ADDR_WIDTH'(1);
          if (s_axis_tlast) begin
            pkt_words_nxt = {1'b0, wptr} + (ADDR_WIDTH+1)'(1);
            state_nxt     = START;
          end else if (wptr == WPTR_MAX) begin
            // Last slot written; the rest of this packet is discarded.
            ovf_nxt   = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) state_nxt = IDLE;
      end
      START: begin
        start_nxt  = 1'b1;
        to_cnt_nxt = '0;
        state_nxt  = WAIT_STARTED;
      end
      WAIT_STARTED: begin
        to_cnt_nxt = to_cnt + TO_W'(1);
        if (phy_tx_started) begin
          if (phy_tx_done) begin
            tx_pkt_cnt_nxt = tx_pkt_cnt + 16'd1;
            state_nxt      = IDLE;
          end else begin
            state_nxt = WAIT_DONE;
          end
        end else if (to_cnt == TO_LAST) begin
          to_err_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (phy_tx_done) begin
          tx_pkt_cnt_nxt = tx_pkt_cnt + 16'd1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Registered so that tready stays low during reset and rises one cycle after it.
    tready_nxt = (state_nxt == IDLE) || (state_nxt == FILL) || (state_nxt == DROP);
  end

endmodule
